key_schedule_ctrl: RTL
======================

Name: key_schedule_ctrl

Overview:
Sequential AES key-schedule controller. It accepts a cipher key through a valid/ready handshake and expands it iteratively, one 32-bit word per cycle, using a single shared 4-byte S-box (SubWord) stage. The expanded words are held in an internal word store. Round keys are served to the cipher round datapath through a registered request/response read port, so the round datapath can be sequenced against a key schedule that is known to be complete.

Parameters:
Nb, 4, words per state column block (fixed at 4)
Nk, 4, key length in 32-bit words; legal values 4, 6, 8
Nr, 10, number of rounds; must equal Nk+6

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous active-high reset
Key_valid  in  1  key offer
Key_ready  out  1  controller can accept a key
Key  in  32*Nk  cipher key, big-endian; word 0 in the MS bits
Busy  out  1  expansion in progress
Done  out  1  one-cycle pulse when the schedule is complete
Rk_req  in  1  round-key read request
Rk_idx  in  4  requested round, 0..Nr
Rk_valid  out  1  round-key response strobe
Rk_err  out  1  response error flag
Round_key  out  128  words 4r..4r+3; word 4r in the MS bits

Behaviour:
- Reset: state IDLE; Key_ready=1; Busy=0; Done=0; Rk_valid=0; Rk_err=0; Round_key=0.
- Reset: word store cleared, i=0, rcon=8'h01.
- Reset mid-EXPAND aborts the expansion; no Done pulse is issued afterwards.
- States: IDLE, EXPAND, READY.
- Key_ready=1 in IDLE and READY; Key_ready=0 in EXPAND. A key offered during EXPAND is not accepted.
- Accept edge (Key_valid & Key_ready):
  - store w[0..Nk-1] from Key; i<=Nk; rcon<=8'h01; go to EXPAND.
  - In READY, this invalidates the previous schedule.
- EXPAND, one word per cycle. Let t=w[i-1].
  - If i%Nk==0: t = SubWord(RotWord(t)) ^ {rcon,24'h0}; then rcon <= xtime(rcon), so 8'h80 goes to 8'h1b.
  - Else if Nk==8 and i%Nk==4: t = SubWord(t).
  - Write w[i] = w[i-Nk] ^ t; i<=i+1.
- Completion:
  - When w[Nb*(Nr+1)-1] is written, go to READY.
  - Done=1 for exactly the first READY cycle.
  - Expansion takes Nb*(Nr+1)-Nk cycles from the accept edge to Done: 40 for Nk=4, 46 for Nk=6, 52 for Nk=8.
- Busy=1 exactly while in EXPAND.
- Round-key port: Rk_req is sampled each edge; the response appears on the next cycle.
  - Rk_valid=1 for one cycle per request; Rk_valid, Rk_err and Round_key are registered.
  - In READY with Rk_idx<=Nr: Round_key = {w[4r],w[4r+1],w[4r+2],w[4r+3]}; Rk_err=0.
  - Rk_idx>Nr, or a request received in IDLE or EXPAND: Rk_valid=1, Rk_err=1, Round_key=0.
  - Back-to-back requests are served on consecutive cycles.
  - Round_key holds its last value when there is no request.
- Simultaneous key accept and Rk_req in READY: the request is evaluated against the pre-accept schedule, so it returns valid data.
- S-box: standard AES forward S-box as combinational lookup; only one SubWord instance is permitted.
- Word store: Nb*(Nr+1) x 32 registers.

Test Plan:
- Nk=4, Key=2b7e151628aed2a6abf7158809cf4f3c -> Done 40 cycles after accept; Rk_idx=1 returns a0fafe1788542cb123a339392a6c7605; Rk_idx=10 returns d014f9a8c9ee2589e13f0cc8b6630ca6.
- Nk=6, Key=8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b -> Done after 46 cycles; Rk_idx=12 returns a low word of 01002202.
- Nk=8, Key=603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4 -> Done after 52 cycles; Rk_idx=14 returns a low word of 706c631e.
- Rk_req during EXPAND, and Rk_idx=11 with Nk=4 in READY -> Rk_valid=1, Rk_err=1, Round_key=0; Key_valid held during EXPAND -> not accepted (Key_ready=0).
- Assert rst at cycle 20 of an expansion -> next cycle IDLE, Busy=0, no Done pulse; a new key then expands correctly with rcon restarting at 01.
- In READY, new key accepted on the same edge as Rk_idx=0 -> response returns the old round-0 key; subsequent requests return Rk_err until the new Done.

Source files
------------

// File: rtl/key_schedule_ctrl.sv
// Iterative AES key-schedule controller: expands one 32-bit word per cycle through a single
// shared SubWord stage and serves round keys through a registered request/response port.
module key_schedule_ctrl #(
  parameter int unsigned Nb = 4,
  parameter int unsigned Nk = 4,
  parameter int unsigned Nr = 10
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            Key_valid,
  output logic            Key_ready,
  input  logic [32*Nk-1:0] Key,
  output logic            Busy,
  output logic            Done,
  input  logic            Rk_req,
  input  logic [3:0]      Rk_idx,
  output logic            Rk_valid,
  output logic            Rk_err,
  output logic [127:0]    Round_key
);

  localparam int unsigned NumWords = Nb * (Nr + 1);
  localparam int unsigned IdxW     = $clog2(NumWords + 1);

  // Forward AES S-box, byte b at bits [8*(255-b) +: 8].
  localparam logic [2047:0] SboxTable = {
    256'h637c777bf26b6fc53001672bfed7ab76ca82c97dfa5947f0add4a2af9ca472c0,
    256'hb7fd9326363ff7cc34a5e5f171d8311504c723c31896059a071280e2eb27b275,
    256'h09832c1a1b6e5aa0523bd6b329e32f8453d100ed20fcb15b6acbbe394a4c58cf,
    256'hd0efaafb434d338545f9027f503c9fa851a3408f929d38f5bcb6da2110fff3d2,
    256'hcd0c13ec5f974417c4a77e3d645d197360814fdc222a908846eeb814de5e0bdb,
    256'he0323a0a4906245cc2d3ac629195e479e7c8376d8dd54ea96c56f4ea657aae08,
    256'hba78252e1ca6b4c6e8dd741f4bbd8b8a703eb5664803f60e613557b986c11d9e,
    256'he1f8981169d98e949b1e87e9ce5528df8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SboxTable[{~b, 3'b000} +: 8];
  endfunction

  typedef enum logic [1:0] {StIdle, StExpand, StReady} state_e;

  state_e            state_q;
  logic [31:0]       w_q [NumWords];
  logic [IdxW-1:0]   i_q;
  logic [2:0]        kc_q;   // i_q % Nk, kept as a wrapping counter
  logic [7:0]        rcon_q;
  logic              key_ready_q, busy_q, done_q, rk_valid_q, rk_err_q;
  logic [127:0]      round_key_q;

  logic [31:0]       prev_w, back_w, sub_in, sub_out, temp_w, new_w;
  logic [7:0]        rcon_next;
  logic [IdxW-1:0]   rk_base;
  logic              rk_ok;

  always_comb begin
    prev_w    = w_q[i_q - IdxW'(1)];
    back_w    = w_q[i_q - IdxW'(Nk)];
    sub_in    = (kc_q == 3'd0) ? {prev_w[23:0], prev_w[31:24]} : prev_w;
    sub_out   = {sbox(sub_in[31:24]), sbox(sub_in[23:16]), sbox(sub_in[15:8]), sbox(sub_in[7:0])};
    if (kc_q == 3'd0) begin
      temp_w = sub_out ^ {rcon_q, 24'h0};
    end else if ((Nk == 8) && (kc_q == 3'd4)) begin
      temp_w = sub_out;
    end else begin
      temp_w = prev_w;
    end
    new_w     = back_w ^ temp_w;
    rcon_next = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
    rk_base   = IdxW'({Rk_idx, 2'b00});
    rk_ok     = (state_q == StReady) && (Rk_idx <= 4'(Nr));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      i_q         <= '0;
      kc_q        <= '0;
      rcon_q      <= 8'h01;
      key_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      rk_valid_q  <= 1'b0;
      rk_err_q    <= 1'b0;
      round_key_q <= '0;
      for (int j = 0; j < NumWords; j++) w_q[j] <= '0;
    end else begin
      done_q     <= 1'b0;
      rk_valid_q <= Rk_req;
      // Reads see the pre-edge state, so a request coinciding with a key accept gets old data.
      if (Rk_req) begin
        if (rk_ok) begin
          round_key_q <= {w_q[rk_base], w_q[rk_base + IdxW'(1)],
                          w_q[rk_base + IdxW'(2)], w_q[rk_base + IdxW'(3)]};
          rk_err_q    <= 1'b0;
        end else begin
          round_key_q <= '0;
          rk_err_q    <= 1'b1;
        end
      end else begin
        rk_err_q <= 1'b0;
      end

      unique case (state_q)
        StIdle, StReady: begin
          if (Key_valid) begin
            for (int j = 0; j < Nk; j++) w_q[j] <= Key[32*(Nk-1-j) +: 32];
            i_q         <= IdxW'(Nk);
            kc_q        <= '0;
            rcon_q      <= 8'h01;
            state_q     <= StExpand;
            key_ready_q <= 1'b0;
            busy_q      <= 1'b1;
          end
        end
        StExpand: begin
          w_q[i_q] <= new_w;
          i_q      <= i_q + IdxW'(1);
          kc_q     <= (kc_q == 3'(Nk - 1)) ? 3'd0 : kc_q + 3'd1;
          if (kc_q == 3'd0) rcon_q <= rcon_next;
          if (i_q == IdxW'(NumWords - 1)) begin
            state_q     <= StReady;
            key_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign Key_ready = key_ready_q;
  assign Busy      = busy_q;
  assign Done      = done_q;
  assign Rk_valid  = rk_valid_q;
  assign Rk_err    = rk_err_q;
  assign Round_key = round_key_q;

endmodule
